image_rom_arbiter: RTL
======================

Name: image_rom_arbiter

Overview:
Shares the single-port, registered-output `image_rom` between N pixel-drawing requesters, for example two `draw_rect` sprite layers. Each cycle it grants at most one request, round-robin by default. It drives the ROM address and routes the returned RGB word back to the granted requester with a fixed latency. It sits between the drawing pipeline stages and `u_image_rom` in `top_vga`.

Parameters:
N, 2, number of requesters (2..8)
AW, 12, ROM address width
DW, 12, ROM data (RGB444) width
ROM_LAT, 1, ROM read latency in clock edges from address to rgb valid
RR, 1, 1 = round-robin, 0 = fixed priority (index 0 highest)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
req  in  N  per-requester read request, level
addr  in  N*AW  per-requester address; slice i = addr[i*AW +: AW]
gnt  out  N  one-hot grant, combinational, same cycle as req
rsp_valid  out  N  one-hot response strobe, registered
rsp_data  out  DW  read data, shared by all requesters; qualified by rsp_valid
rom_address  out  AW  to image_rom.address, registered
rom_rgb  in  DW  from image_rom.rgb

Behaviour:
- Reset (rst==0 at posedge):
  - rom_address=0, tag pipeline cleared, rsp_valid=0.
  - Priority pointer = 0.
  - gnt is forced to 0 while rst==0.
- Grant, combinational:
  - RR=1: gnt[i]=1 for the first i with req[i]=1, searching ptr, ptr+1, ... mod N.
  - RR=0: lowest asserted index wins.
  - gnt is never more than one-hot; gnt=0 when req=0.
- Pointer update at posedge when any grant is given: ptr <= (granted index + 1) mod N. With no grant, ptr holds.
- Grant cycle C:
  - At the end of C: rom_address <= addr[granted].
  - A tag {valid=1, idx} enters a shift register of depth ROM_LAT+1.
  - With no grant, rom_address holds its last value and the tag enters with valid=0.
- Response:
  - rsp_valid[idx]=1 for exactly one cycle, C+ROM_LAT+1.
  - rsp_data = rom_rgb in that cycle, passed through combinationally.
  - Default total latency is 2 cycles.
- Throughput: one grant per cycle, fully pipelined. Back-to-back grants produce back-to-back responses in grant order.
- Request handshake:
  - A requester holds req and a stable addr until it sees gnt.
  - It may deassert req without a grant; this has no side effects.
  - A requester whose req stays high after gnt is treated as a new request in the next cycle.
- Fairness, RR=1: with all N requesting continuously, each is granted exactly once per N cycles. Maximum wait is N-1 cycles.
- rsp_data is undefined, and not asserted to 0, when all rsp_valid are 0.
- Reset mid-operation:
  - In-flight tags are discarded, so no rsp_valid fires for requests granted before reset.
  - The first grant after reset goes to the lowest requesting index.
- Out-of-range ROM addresses are passed unchanged; bounds checking is the requester's job.

Test Plan:
- Single request: N=2, req=2'b01, addr0=12'h123 for 1 cycle → gnt=01 in that cycle, rom_address=123 one cycle later, rsp_valid=01 two cycles after grant with rsp_data equal to ROM[0x123].
- Contention: req=2'b11 held for 6 cycles, addr0=0x010, addr1=0x020 → gnt sequence 01,10,01,10,01,10; rsp_valid follows the same sequence delayed by 2 cycles, each with matching ROM data.
- Fixed priority: RR=0, req=2'b11 held for 4 cycles → gnt=01 on every cycle; rsp_valid[1] never asserts.
- Idle hold: one grant to addr=0x3FF, then req=0 for 5 cycles → rom_address stays 0x3FF, rsp_valid stays 0 after the single response.
- Reset mid-flight: grant at cycle C, rst=0 at C+1 → no rsp_valid at C+2; rom_address=0; gnt=0 during reset. After release with req=2'b11, the first gnt is 01.
- Scaled configuration: N=3, ROM_LAT=2, all requesting for 9 cycles → gnt rotates 001,010,100 three times; each rsp_valid arrives exactly 3 cycles after its grant with correct data; the bench scoreboard compares against a ROM model.

Source files
------------

// File: rtl/image_rom_arbiter_if.sv
// image_rom_arbiter_if
//   Requester-side bundle of the image ROM arbiter. The drawing stages sit
//   on the master side; the arbiter is the slave.
//
//   req       : per-requester read request, level (N bits)
//   addr      : packed per-requester ROM addresses, slice i = addr[i*AW +: AW]
//   gnt       : one-hot grant, combinational in the request cycle
//   rsp_valid : one-hot response strobe, registered
//   rsp_data  : shared read data, qualified by rsp_valid
interface image_rom_arbiter_if #(
  parameter int N  = 2,
  parameter int AW = 12,
  parameter int DW = 12
);
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter
//   Shares the single-port, registered-output image ROM between N pixel
//   drawing requesters. At most one request is granted per cycle
//   (round-robin or fixed priority), the granted address is registered onto
//   the ROM, and the returned RGB word is steered back to the granted
//   requester ROM_LAT+1 cycles after the grant.
//
//   clk         : system clock
//   rst         : synchronous, active-low reset
//   bus         : requester bundle (req/addr in, gnt/rsp_valid/rsp_data out)
//   rom_address : registered address to image_rom.address
//   rom_rgb     : data from image_rom.rgb, passed straight to bus.rsp_data
module image_rom_arbiter #(
  parameter int N       = 2,
  parameter int AW      = 12,
  parameter int DW      = 12,
  parameter int ROM_LAT = 1,
  parameter int RR      = 1
) (
  input  logic                clk,
  input  logic                rst,
  image_rom_arbiter_if.slave  bus,
  output logic [AW-1:0]       rom_address,
  input  logic [DW-1:0]       rom_rgb
);

  // Index width for requester numbers; CW has one spare bit so the
  // pointer-plus-offset sum can exceed N before it is wrapped.
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = IW + 1;
  localparam int PW = 1 << IW;

  logic [IW-1:0] ptr;
  logic [IW-1:0] next_ptr;
  logic [PW-1:0] req_pad;
  logic [CW-1:0] cand;
  logic          found;
  logic          grant_any;
  logic [IW-1:0] grant_idx;
  logic [AW-1:0] grant_addr;

  logic [ROM_LAT-1:0] tag_valid;
  logic [IW-1:0]      tag_idx [ROM_LAT];
  logic [N-1:0]       rsp_valid_q;

  function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = (idx == IW'(i));
    end
    return v;
  endfunction

  // Grant search. In round-robin mode the candidates are visited starting at
  // the priority pointer and wrapping at N; in fixed mode the pointer is
  // ignored and index 0 is tried first. The request vector is zero-padded
  // to a power of two so a wrapped candidate can always index it.
  always_comb begin
    req_pad          = '0;
    req_pad[N-1:0]   = bus.req;
    found            = 1'b0;
    grant_idx        = '0;
    cand             = '0;
    for (int k = 0; k < N; k++) begin
      if (RR != 0) begin
        cand = CW'(ptr) + CW'(k);
        if (cand >= CW'(N)) begin
          cand = cand - CW'(N);
        end
      end else begin
        cand = CW'(k);
      end
      if (!found && req_pad[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  // Grants are suppressed while reset is held so nothing is launched into a
  // pipeline that is being cleared.
  assign grant_any = found & rst;
  assign bus.gnt   = grant_any ? to_onehot(grant_idx) : '0;

  // Address mux for the winner, written with constant slices only.
  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IW'(i)) begin
        grant_addr = bus.addr[i*AW +: AW];
      end
    end
  end

  assign next_ptr = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);

  // ROM address register, priority pointer and the tag pipeline that
  // remembers who owns each in-flight read. The last tag stage is decoded
  // into the registered one-hot rsp_valid, lining it up with the cycle in
  // which the ROM presents the data for that read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_address <= '0;
      ptr         <= '0;
      tag_valid   <= '0;
      rsp_valid_q <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        tag_idx[s] <= '0;
      end
    end else begin
      if (grant_any) begin
        rom_address <= grant_addr;
        ptr         <= next_ptr;
      end
      tag_valid[0] <= grant_any;
      tag_idx[0]   <= grant_idx;
      for (int s = 1; s < ROM_LAT; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_idx[s]   <= tag_idx[s-1];
      end
      rsp_valid_q <= tag_valid[ROM_LAT-1] ? to_onehot(tag_idx[ROM_LAT-1]) : '0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rom_rgb;

endmodule
